sized_data_memory: RTL and testbench



---
 rtl/data_memory_pkg.sv | 40 ++++
 rtl/load_extender.sv | 37 +++
 rtl/sized_data_memory.sv | 117 +++++++++++
 tb/tb_sized_data_memory.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// data_memory_pkg: access-size encoding and byte-lane helpers for sized_data_memory.
`default_nettype none

package data_memory_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } size_e;

  localparam int DATA_BYTES = 8;

  // An access is aligned when its byte offset is a multiple of its own size.
  function automatic logic is_aligned(input logic [2:0] offset, input size_e size);
    logic ok;
    case (size)
      SIZE_B:  ok = 1'b1;
      SIZE_H:  ok = (offset[0] == 1'b0);
      SIZE_W:  ok = (offset[1:0] == 2'b00);
      default: ok = (offset == 3'b000);
    endcase
    return ok;
  endfunction

  function automatic logic [DATA_BYTES-1:0] lane_mask(input logic [2:0] offset, input size_e size);
    logic [DATA_BYTES-1:0] base;
    case (size)
      SIZE_B:  base = 8'h01;
      SIZE_H:  base = 8'h03;
      SIZE_W:  base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << offset;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_extender.sv
// load_extender: picks the addressed bytes out of a 64-bit word and
// sign- or zero-extends them to 64 bits.
`default_nettype none

module load_extender
  import data_memory_pkg::*;
(
  input  logic [63:0] i_word,
  input  logic [2:0]  i_offset,
  input  size_e       i_size,
  input  logic        i_signed,
  output logic [63:0] o_data
);

  logic [63:0] w_shifted;
  logic        w_sign_b;
  logic        w_sign_h;
  logic        w_sign_w;

  assign w_shifted = i_word >> {i_offset, 3'b000};
  assign w_sign_b  = i_signed & w_shifted[7];
  assign w_sign_h  = i_signed & w_shifted[15];
  assign w_sign_w  = i_signed & w_shifted[31];

  always_comb begin
    o_data = w_shifted;
    case (i_size)
      SIZE_B:  o_data = {{56{w_sign_b}}, w_shifted[7:0]};
      SIZE_H:  o_data = {{48{w_sign_h}}, w_shifted[15:0]};
      SIZE_W:  o_data = {{32{w_sign_w}}, w_shifted[31:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sized_data_memory.sv
// sized_data_memory: byte-addressed data memory with sized, extended loads,
// lane-masked stores, error flagging and a READ_LATENCY-deep response pipeline.
`default_nettype none

module sized_data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 64,
  parameter int DEPTH        = 64,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WORD_W = ADDR_WIDTH - 3;
  localparam int LAST   = READ_LATENCY - 1;

  logic [WORD_W-1:0]     w_word_idx;
  logic [IDX_W-1:0]      w_idx;
  logic [2:0]            w_offset;
  size_e                 w_size;
  logic                  w_misaligned;
  logic                  w_out_of_range;
  logic                  w_error;
  logic                  w_advance;
  logic                  w_accept;
  logic                  w_do_write;
  logic [DATA_BYTES-1:0] w_lane_mask;
  logic [DATA_WIDTH-1:0] w_wdata_shifted;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [DATA_WIDTH-1:0] w_resp_data;

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [READ_LATENCY-1:0] r_vld;
  logic [READ_LATENCY-1:0] r_err;
  logic [DATA_WIDTH-1:0]   r_data [READ_LATENCY];

  assign w_word_idx     = req_addr[ADDR_WIDTH-1:3];
  assign w_offset       = req_addr[2:0];
  assign w_size         = size_e'(req_size);
  assign w_idx          = w_word_idx[IDX_W-1:0];
  assign w_misaligned   = !is_aligned(w_offset, w_size);
  assign w_out_of_range = (w_word_idx >= WORD_W'(DEPTH));
  assign w_error        = w_misaligned || w_out_of_range;

  // Whole pipeline moves together; a stalled output freezes every stage.
  assign w_advance  = !r_vld[LAST] || resp_ready;
  assign req_ready  = w_advance;
  assign w_accept   = req_valid && w_advance;
  assign w_do_write = w_accept && req_write && !w_error;

  assign w_lane_mask     = lane_mask(w_offset, w_size);
  assign w_wdata_shifted = req_wdata << {w_offset, 3'b000};
  assign w_rd_word       = r_mem[w_idx];

  load_extender u_load_extender (
    .i_word   (w_rd_word),
    .i_offset (w_offset),
    .i_size   (w_size),
    .i_signed (req_signed),
    .o_data   (w_load_data)
  );

  assign w_resp_data = (req_write || w_error) ? '0 : w_load_data;

  // Array is deliberately not reset so committed stores survive a reset.
  always_ff @(posedge clock) begin
    if (w_do_write) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (w_lane_mask[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata_shifted[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
      r_err <= '0;
      for (int s = 0; s < READ_LATENCY; s++) begin
        r_data[s] <= '0;
      end
    end else if (w_advance) begin
      r_vld[0]  <= w_accept;
      r_err[0]  <= w_accept && w_error;
      r_data[0] <= w_accept ? w_resp_data : '0;
      for (int s = 1; s < READ_LATENCY; s++) begin
        r_vld[s]  <= r_vld[s-1];
        r_err[s]  <= r_err[s-1];
        r_data[s] <= r_data[s-1];
      end
    end
  end

  assign resp_valid = r_vld[LAST];
  assign resp_error = r_err[LAST];
  assign resp_rdata = r_data[LAST];

endmodule

`default_nettype wire

// File: tb/tb_sized_data_memory.sv
// tb_sized_data_memory: directed and randomized checks of sized_data_memory
// against a byte-array reference model with an in-order response queue.
`default_nettype none

module tb_sized_data_memory;

  localparam int LAT   = 3;
  localparam int DEPTH = 64;
  localparam int AW    = 64;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_error;
  logic [63:0] resp_rdata;

  sized_data_memory #(
    .DATA_WIDTH   (64),
    .ADDR_WIDTH   (AW),
    .DEPTH        (DEPTH),
    .READ_LATENCY (LAT)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_resp   = 0;
  logic [7:0]  mem_m [DEPTH*8];
  logic [64:0] exp_q [$];
  logic        obs_rv, obs_qr, obs_re, prev_hold;
  logic [63:0] obs_rd, last_data;
  logic        last_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
  endtask

  // Reference behaviour: returns {error, rdata}; stores update the byte array.
  function automatic logic [64:0] model_access(input logic wr, input logic [1:0] sz, input logic sgn,
                                               input logic [63:0] addr, input logic [63:0] wd);
    int          nb  = 1 << sz;
    logic [63:0] val = '0;
    if ((addr % 64'(nb)) != 0 || (addr >> 3) >= 64'(DEPTH)) return {1'b1, 64'd0};
    if (wr) begin
      for (int b = 0; b < nb; b++) mem_m[addr + 64'(b)] = wd[8*b +: 8];
      return {1'b0, 64'd0};
    end
    for (int b = 0; b < nb; b++) val[8*b +: 8] = mem_m[addr + 64'(b)];
    if (sgn && nb < 8 && val[8*nb-1]) begin
      for (int b = nb; b < 8; b++) val[8*b +: 8] = 8'hFF;
    end
    return {1'b0, val};
  endfunction

  function automatic logic [63:0] model_word(input int w);
    logic [63:0] v;
    for (int b = 0; b < 8; b++) v[8*b +: 8] = mem_m[w*8 + b];
    return v;
  endfunction

  // One clock cycle: drive at negedge, observe 1ns later, then step to next negedge.
  task automatic cycle(input logic v, input logic wr, input logic [1:0] sz, input logic sgn,
                       input logic [63:0] addr, input logic [63:0] wd, input logic rr);
    logic [64:0] e;
    req_valid = v; req_write = wr; req_size = sz; req_signed = sgn;
    req_addr = addr; req_wdata = wd; resp_ready = rr;
    #1;
    obs_rv = resp_valid; obs_qr = req_ready; obs_rd = resp_rdata; obs_re = resp_error;
    chk("req_ready", obs_qr, !obs_rv || rr);
    if (prev_hold) chk("stall_valid", obs_rv, 1);
    if (obs_rv) begin
      if (exp_q.size() == 0) chk("spurious_resp", obs_rv, 0);
      else begin
        chk("resp_rdata", obs_rd, exp_q[0][63:0]);
        chk("resp_error", obs_re, exp_q[0][64]);
        if (rr) begin
          e = exp_q.pop_front();
          last_data = obs_rd; last_err = obs_re; n_resp++;
        end
      end
    end
    prev_hold = obs_rv && !rr;
    if (v && obs_qr) exp_q.push_back(model_access(wr, sz, sgn, addr, wd));
    chk("occupancy", exp_q.size() <= LAT, 1);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle(input logic rr);
    cycle(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0, rr);
  endtask

  task automatic send(input logic wr, input logic [1:0] sz, input logic sgn,
                      input logic [63:0] addr, input logic [63:0] wd);
    bit done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      cycle(1'b1, wr, sz, sgn, addr, wd, 1'b1);
      done = obs_qr;
    end
    chk("send_accepted", done, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) idle(1'b1);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          idx, cyc, start, first, acc;
    bit          saw_stall;
    logic [1:0]  sz;
    logic [63:0] a;

    req_valid = 0; req_write = 0; req_size = 0; req_signed = 0;
    req_addr = 0; req_wdata = 0; resp_ready = 0; prev_hold = 0;
    last_data = 0; last_err = 0;
    @(negedge clock); #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_error", resp_error, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    for (int w = 0; w < DEPTH; w++) send(1'b1, 2'd3, 1'b0, 64'(w*8), {$urandom, $urandom});
    drain();

    send(1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788);
    send(1'b0, 2'd3, 1'b0, 64'h10, 64'd0);
    drain();
    chk("ld_d", last_data, 64'h1122334455667788);
    chk("ld_d_err", last_err, 0);

    send(1'b1, 2'd0, 1'b0, 64'h13, 64'h80);
    send(1'b0, 2'd0, 1'b1, 64'h13, 64'd0);
    drain();
    chk("ld_b_signed", last_data, 64'hFFFFFFFFFFFFFF80);
    send(1'b0, 2'd0, 1'b0, 64'h13, 64'd0);
    drain();
    chk("ld_b_unsigned", last_data, 64'h80);
    send(1'b0, 2'd3, 1'b0, 64'h10, 64'd0);
    drain();
    chk("ld_d_after_byte", last_data, 64'h1122334480667788);

    send(1'b0, 2'd2, 1'b0, 64'h12, 64'd0);
    drain();
    chk("misaligned_err", last_err, 1);
    chk("misaligned_data", last_data, 0);
    send(1'b1, 2'd3, 1'b0, 64'(DEPTH*8), 64'hDEADBEEFDEADBEEF);
    drain();
    chk("oor_err", last_err, 1);
    send(1'b0, 2'd3, 1'b0, 64'd0, 64'd0);
    drain();
    chk("oor_unchanged", last_data, model_word(0));

    idx = 0; cyc = 0; saw_stall = 0; start = n_resp;
    while (idx < 4 && cyc < 30) begin
      cycle(1'b1, 1'b0, 2'd3, 1'b0, 64'(16 + idx*8), 64'd0, cyc >= LAT + 2);
      if (!obs_qr) saw_stall = 1'b1;
      else idx++;
      cyc++;
    end
    chk("bp_all_sent", idx, 4);
    chk("bp_stall_seen", saw_stall, 1);
    drain();
    chk("bp_resp_count", n_resp - start, 4);

    send(1'b1, 2'd3, 1'b0, 64'h20, 64'hCAFEF00D12345678);
    drain();
    cycle(1'b1, 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 1'b0);
    cycle(1'b1, 1'b0, 2'd3, 1'b0, 64'h18, 64'd0, 1'b0);
    for (int k = 0; k < LAT; k++) idle(1'b0);
    chk("pre_reset_valid", resp_valid, 1);
    req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_rdata", resp_rdata, 0);
    chk("mid_rst_error", resp_error, 0);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    prev_hold = 1'b0;
    start = n_resp;
    for (int k = 0; k < LAT + 3; k++) idle(1'b1);
    chk("post_rst_no_resp", n_resp - start, 0);
    send(1'b0, 2'd3, 1'b0, 64'h20, 64'd0);
    drain();
    chk("post_rst_store_kept", last_data, 64'hCAFEF00D12345678);

    cycle(1'b1, 1'b0, 2'd3, 1'b0, 64'h20, 64'd0, 1'b1);
    first = 0;
    for (int k = 1; k <= LAT + 4; k++) begin
      idle(1'b1);
      if (obs_rv && first == 0) first = k;
    end
    chk("latency", first, LAT);

    start = n_resp; acc = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 1'b0, 2'd3, 1'b0, 64'($urandom_range(0, DEPTH-1) * 8), 64'd0, 1'b1);
      if (obs_qr) acc++;
    end
    for (int k = 0; k < LAT; k++) idle(1'b1);
    chk("stream_accepts", acc, 8);
    chk("stream_resps", n_resp - start, 8);

    for (int i = 0; i < 600; i++) begin
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       a = {$urandom, $urandom};
        1:       a = 64'($urandom_range(0, DEPTH*8 + 64));
        default: a = 64'(($urandom_range(0, DEPTH*8 - 1) >> sz) << sz);
      endcase
      cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
            a, {$urandom, $urandom}, $urandom_range(0, 9) < 7);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
